// File: rtl/calendario_ctrl_if.sv
// Bundle of pulse inputs and registered date/status outputs of the calendar controller.
// The bench side takes master; the controller takes slave.
interface calendario_ctrl_if;
   logic       tick;
   logic       mode;
   logic       inc;
   logic [3:0] du;
   logic [3:0] dd;
   logic [3:0] mu;
   logic [3:0] md;
   logic [1:0] state;
   logic       wrap;
   logic       busy;
   logic       ovf;

   modport master (
      output tick, mode, inc,
      input  du, dd, mu, md, state, wrap, busy, ovf
   );

   modport slave (
      input  tick, mode, inc,
      output du, dd, mu, md, state, wrap, busy, ovf
   );
endinterface

// File: rtl/calendario_ctrl.sv
// BCD day/month calendar with a mode/inc edit FSM. Ticks that arrive while editing
// are counted and replayed one day per cycle once the FSM returns to RUN.
module calendario_ctrl #(
   parameter int FEB_DAYS = 28,
   parameter int PEND_W   = 5
) (
   input logic              clk,
   input logic              rst,
   calendario_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_M = 2'd1,
      SET_D = 2'd2
   } state_t;

   localparam logic [PEND_W-1:0] COUNT_MAX = '1;

   state_t            state_reg, state_next;
   logic [3:0]        du_reg, du_next;
   logic [3:0]        dd_reg, dd_next;
   logic [3:0]        mu_reg, mu_next;
   logic [3:0]        md_reg, md_next;
   logic [PEND_W-1:0] count_reg, count_next;
   logic              wrap_reg, wrap_next;
   logic              busy_reg, busy_next;
   logic              ovf_reg, ovf_next;

   logic [4:0]        day_cur, day_last, day_new;
   logic [3:0]        month_cur, month_new;

   function automatic logic [4:0] last_of(input logic [3:0] m);
      case (m)
         4'd2:                    return 5'(FEB_DAYS);
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         default:                 return 5'd31;
      endcase
   endfunction

   // Values never exceed 31, so a three-step tens compare is enough.
   function automatic logic [7:0] to_bcd(input logic [4:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      if (v >= 5'd30)      tens = 4'd3;
      else if (v >= 5'd20) tens = 4'd2;
      else if (v >= 5'd10) tens = 4'd1;
      else                 tens = 4'd0;
      units = 4'(v - {1'b0, tens} * 5'd10);
      return {tens, units};
   endfunction

   always_comb begin
      day_cur   = {1'b0, dd_reg} * 5'd10 + {1'b0, du_reg};
      month_cur = md_reg * 4'd10 + mu_reg;
      day_last  = last_of(month_cur);
   end

   always_comb begin
      state_next = state_reg;
      day_new    = day_cur;
      month_new  = month_cur;
      count_next = count_reg;
      wrap_next  = 1'b0;
      ovf_next   = ovf_reg;

      case (state_reg)
         RUN: begin
            // A live tick and a pending replay share the same single-day advance.
            if (bus.tick || count_reg != '0) begin
               if (day_cur < day_last) begin
                  day_new = day_cur + 5'd1;
               end else begin
                  day_new = 5'd1;
                  if (month_cur == 4'd12) begin
                     month_new = 4'd1;
                     wrap_next = 1'b1;
                  end else begin
                     month_new = month_cur + 4'd1;
                  end
               end
               if (!bus.tick && count_reg != '0)
                  count_next = count_reg - 1'b1;
            end
            if (bus.mode)
               state_next = SET_M;
         end

         SET_M, SET_D: begin
            if (bus.tick) begin
               if (count_reg == COUNT_MAX) ovf_next = 1'b1;
               else                        count_next = count_reg + 1'b1;
            end
            if (bus.mode) begin
               if (state_reg == SET_M) begin
                  state_next = SET_D;
                  if (day_cur > day_last)
                     day_new = day_last;
               end else begin
                  state_next = RUN;
               end
            end else if (bus.inc) begin
               if (state_reg == SET_M)
                  month_new = (month_cur == 4'd12) ? 4'd1 : month_cur + 4'd1;
               else
                  day_new = (day_cur >= day_last) ? 5'd1 : day_cur + 5'd1;
            end
         end

         default: state_next = RUN;
      endcase

      busy_next          = (count_next != '0);
      {dd_next, du_next} = to_bcd(day_new);
      {md_next, mu_next} = to_bcd({1'b0, month_new});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RUN;
         du_reg    <= 4'd1;
         dd_reg    <= 4'd0;
         mu_reg    <= 4'd1;
         md_reg    <= 4'd0;
         count_reg <= '0;
         wrap_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         du_reg    <= du_next;
         dd_reg    <= dd_next;
         mu_reg    <= mu_next;
         md_reg    <= md_next;
         count_reg <= count_next;
         wrap_reg  <= wrap_next;
         busy_reg  <= busy_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign bus.du    = du_reg;
   assign bus.dd    = dd_reg;
   assign bus.mu    = mu_reg;
   assign bus.md    = md_reg;
   assign bus.state = state_reg;
   assign bus.wrap  = wrap_reg;
   assign bus.busy  = busy_reg;
   assign bus.ovf   = ovf_reg;

endmodule

// File: tb/tb_calendario_ctrl.sv
// Bench for calendario_ctrl: directed scenarios plus random pulses, all compared
// against an integer day/month model of the calendar rules.
module tb_calendario_ctrl;
   localparam int FEB_DAYS = 28;
   localparam int PEND_W   = 5;
   localparam int MAXC     = (1 << PEND_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   calendario_ctrl_if bus();

   calendario_ctrl #(.FEB_DAYS(FEB_DAYS), .PEND_W(PEND_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state: plain integers, 0=RUN 1=SET_M 2=SET_D.
   int m_day, m_mon, m_st, m_cnt;
   bit m_ovf, m_wrap;
   int dim [12] = '{31, FEB_DAYS, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

   function automatic int month_len(int mon);
      return dim[mon-1];
   endfunction

   function automatic logic [20:0] exp_vec();
      return {4'(m_day / 10), 4'(m_day % 10), 4'(m_mon / 10), 4'(m_mon % 10),
              2'(m_st), m_wrap, (m_cnt != 0), m_ovf};
   endfunction

   function automatic logic [20:0] got_vec();
      return {bus.dd, bus.du, bus.md, bus.mu, bus.state, bus.wrap, bus.busy, bus.ovf};
   endfunction

   task automatic model_reset();
      m_day = 1; m_mon = 1; m_st = 0; m_cnt = 0; m_ovf = 0; m_wrap = 0;
   endtask

   task automatic model_step(bit t, bit m, bit i);
      m_wrap = 0;
      if (m_st == 0) begin
         if (t || m_cnt > 0) begin
            if (m_day < month_len(m_mon)) m_day++;
            else begin
               m_day = 1;
               if (m_mon == 12) begin m_mon = 1; m_wrap = 1; end
               else m_mon++;
            end
            if (!t && m_cnt > 0) m_cnt--;
         end
         if (m) m_st = 1;
      end else begin
         if (t) begin
            if (m_cnt == MAXC) m_ovf = 1;
            else m_cnt++;
         end
         if (m) begin
            if (m_st == 1) begin
               m_st = 2;
               if (m_day > month_len(m_mon)) m_day = month_len(m_mon);
            end else m_st = 0;
         end else if (i) begin
            if (m_st == 1) m_mon = m_mon % 12 + 1;
            else m_day = m_day % month_len(m_mon) + 1;
         end
      end
   endtask

   task automatic step(bit t, bit m, bit i);
      bus.tick = t; bus.mode = m; bus.inc = i;
      @(posedge clk);
      model_step(t, m, i);
      #1;
      bus.tick = 1'b0; bus.mode = 1'b0; bus.inc = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #3;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.tick = 1'b0; bus.mode = 1'b0; bus.inc = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_state got=%h exp=%h", got_vec(), exp_vec());
      end
      checks++;
      if ({bus.dd, bus.du, bus.md, bus.mu} !== 16'h0101) begin
         errors++; $display("FAIL reset_date got=%h exp=0101", {bus.dd, bus.du, bus.md, bus.mu});
      end
      rst = 1'b1;
      step(1, 0, 0);
      checks++;
      if ({bus.dd, bus.du, bus.md, bus.mu} !== 16'h0201) begin
         errors++; $display("FAIL first_edge_tick got=%h exp=0201", {bus.dd, bus.du, bus.md, bus.mu});
      end
      $display("test_reset: date=%h%h/%h%h", bus.dd, bus.du, bus.md, bus.mu);
   endtask

   task automatic test_59_ticks();
      bit wrap_seen = 0;
      do_reset();
      for (int k = 0; k < 59; k++) begin
         step(1, 0, 0);
         if (bus.wrap) wrap_seen = 1;
      end
      checks++;
      if ({bus.dd, bus.du, bus.md, bus.mu} !== 16'h0103) begin
         errors++; $display("FAIL ticks59_date got=%h exp=0103", {bus.dd, bus.du, bus.md, bus.mu});
      end
      checks++;
      if (wrap_seen !== 1'b0) begin
         errors++; $display("FAIL ticks59_wrap got=%0d exp=0", wrap_seen);
      end
      $display("test_59_ticks: date=%h%h/%h%h", bus.dd, bus.du, bus.md, bus.mu);
   endtask

   task automatic test_year_wrap();
      step(0, 1, 0);
      for (int k = 0; k < 12 && m_mon != 12; k++) step(0, 0, 1);
      step(0, 1, 0);
      for (int k = 0; k < 31 && m_day != 31; k++) step(0, 0, 1);
      step(0, 1, 0);
      checks++;
      if ({bus.state, bus.dd, bus.du, bus.md, bus.mu} !== {2'd0, 16'h3112}) begin
         errors++; $display("FAIL set_3112 got=%h exp=03112", {bus.state, bus.dd, bus.du, bus.md, bus.mu});
      end
      step(1, 0, 0);
      checks++;
      if ({bus.wrap, bus.dd, bus.du, bus.md, bus.mu} !== {1'b1, 16'h0101}) begin
         errors++; $display("FAIL year_wrap got=%h exp=10101", {bus.wrap, bus.dd, bus.du, bus.md, bus.mu});
      end
      step(0, 0, 0);
      checks++;
      if (bus.wrap !== 1'b0) begin
         errors++; $display("FAIL wrap_one_cycle got=%0d exp=0", bus.wrap);
      end
      $display("test_year_wrap: date=%h%h/%h%h", bus.dd, bus.du, bus.md, bus.mu);
   endtask

   task automatic test_clamp();
      step(0, 1, 0);
      step(0, 1, 0);
      for (int k = 0; k < 31 && m_day != 31; k++) step(0, 0, 1);
      step(0, 1, 0);
      checks++;
      if ({bus.dd, bus.du, bus.md, bus.mu} !== 16'h3101) begin
         errors++; $display("FAIL set_3101 got=%h exp=3101", {bus.dd, bus.du, bus.md, bus.mu});
      end
      step(0, 1, 0);
      step(0, 0, 1);
      checks++;
      if ({bus.dd, bus.du, bus.md, bus.mu} !== 16'h3102) begin
         errors++; $display("FAIL month_inc_no_clamp got=%h exp=3102", {bus.dd, bus.du, bus.md, bus.mu});
      end
      step(0, 1, 0);
      checks++;
      if ({bus.state, bus.dd, bus.du, bus.md, bus.mu} !== {2'd2, 16'h2802}) begin
         errors++; $display("FAIL clamp_feb got=%h exp=22802", {bus.state, bus.dd, bus.du, bus.md, bus.mu});
      end
      step(0, 0, 1);
      checks++;
      if ({bus.dd, bus.du, bus.md, bus.mu} !== 16'h0102) begin
         errors++; $display("FAIL day_inc_wrap got=%h exp=0102", {bus.dd, bus.du, bus.md, bus.mu});
      end
      step(0, 1, 0);
      $display("test_clamp: date=%h%h/%h%h", bus.dd, bus.du, bus.md, bus.mu);
   endtask

   task automatic test_replay();
      step(0, 1, 0);
      repeat (5) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      checks++;
      if ({bus.state, bus.busy, bus.dd, bus.du, bus.md, bus.mu} !== {2'd0, 1'b1, 16'h0102}) begin
         errors++; $display("FAIL replay_entry got=%h exp=%h",
            {bus.state, bus.busy, bus.dd, bus.du, bus.md, bus.mu}, {2'd0, 1'b1, 16'h0102});
      end
      for (int c = 1; c <= 5; c++) begin
         step(0, 0, 0);
         checks++;
         if ({bus.busy, bus.dd, bus.du} !== {(c < 5), 4'((1 + c) / 10), 4'((1 + c) % 10)}) begin
            errors++; $display("FAIL replay_cycle%0d got=%h exp=%h", c,
               {bus.busy, bus.dd, bus.du}, {(c < 5), 4'((1 + c) / 10), 4'((1 + c) % 10)});
         end
      end
      step(0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++; $display("FAIL replay_idle got=%h exp=%h", got_vec(), exp_vec());
      end
      $display("test_replay: date=%h%h/%h%h busy=%0d", bus.dd, bus.du, bus.md, bus.mu, bus.busy);
   endtask

   task automatic test_saturate();
      int cycles = 0;
      step(0, 1, 0);
      for (int k = 1; k <= MAXC + 1; k++) begin
         step(1, 0, 0);
         if (k == MAXC) begin
            checks++;
            if (bus.ovf !== 1'b0) begin
               errors++; $display("FAIL ovf_early got=%0d exp=0", bus.ovf);
            end
         end
      end
      checks++;
      if ({bus.ovf, bus.busy} !== 2'b11) begin
         errors++; $display("FAIL ovf_set got=%b exp=11", {bus.ovf, bus.busy});
      end
      step(0, 1, 0);
      step(0, 1, 0);
      while (bus.busy === 1'b1 && cycles < 100) begin
         step(0, 0, 0);
         cycles++;
      end
      checks++;
      if (cycles !== MAXC) begin
         errors++; $display("FAIL sat_replay_len got=%0d exp=%0d", cycles, MAXC);
      end
      checks++;
      if (got_vec() !== exp_vec() || bus.ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky got=%h exp=%h", got_vec(), exp_vec());
      end
      $display("test_saturate: date=%h%h/%h%h ovf=%0d", bus.dd, bus.du, bus.md, bus.mu, bus.ovf);
   endtask

   task automatic test_mode_inc_and_reset();
      step(0, 1, 1);
      checks++;
      if ({bus.state, bus.md, bus.mu} !== {2'd1, 4'(m_mon / 10), 4'(m_mon % 10)} || m_st != 1) begin
         errors++; $display("FAIL mode_inc_same got=%h exp=%h",
            {bus.state, bus.md, bus.mu}, {2'd1, 4'(m_mon / 10), 4'(m_mon % 10)});
      end
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      repeat (4) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({bus.busy, bus.state, bus.dd, bus.du, bus.md, bus.mu} !== {1'b0, 2'd0, 16'h0101}) begin
         errors++; $display("FAIL async_reset got=%h exp=%h",
            {bus.busy, bus.state, bus.dd, bus.du, bus.md, bus.mu}, {1'b0, 2'd0, 16'h0101});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_discard got=%h exp=%h", got_vec(), exp_vec());
      end
      $display("test_mode_inc_and_reset: date=%h%h/%h%h busy=%0d", bus.dd, bus.du, bus.md, bus.mu, bus.busy);
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++; bad++;
            if (bad <= 10)
               $display("FAIL random_cycle%0d got=%h exp=%h", n, got_vec(), exp_vec());
         end
      end
      $display("test_random: 3000 cycles, last date=%h%h/%h%h", bus.dd, bus.du, bus.md, bus.mu);
   endtask

   initial begin
      test_reset();
      test_59_ticks();
      test_year_wrap();
      test_clamp();
      test_replay();
      test_saturate();
      test_mode_inc_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
